alu_uart_if: RTL and testbench

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_uart_if_pkg.sv | 23 ++
 rtl/alu_uart_if.sv | 91 +++++++++
 tb/tb_alu_uart_if.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_if_pkg.sv
// Shared definitions for the UART-to-ALU bridge: state encoding and default widths.
package alu_uart_if_pkg;

   localparam int DEF_N    = 8;
   localparam int OPCODE_W = 6;

   localparam logic [2:0] ST_WAIT_A  = 3'd0;
   localparam logic [2:0] ST_WAIT_B  = 3'd1;
   localparam logic [2:0] ST_WAIT_OP = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;

   typedef enum logic [2:0] {
      WAIT_A  = ST_WAIT_A,
      WAIT_B  = ST_WAIT_B,
      WAIT_OP = ST_WAIT_OP,
      EXEC    = ST_EXEC,
      SEND    = ST_SEND,
      WAIT_TX = ST_WAIT_TX
   } state_t;

endpackage

// File: rtl/alu_uart_if.sv
// Collects operand A, operand B and an opcode from a UART receiver, lets the
// external ALU settle for one cycle, then hands the result to the UART transmitter.
module alu_uart_if
   import alu_uart_if_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_done,
   input  logic [N-1:0]        rx_data,
   input  logic                tx_done,
   output logic                tx_start,
   output logic [N-1:0]        tx_data,
   output logic [N-1:0]        BusA,
   output logic [N-1:0]        BusB,
   output logic [OPCODE_W-1:0] OpCode,
   input  logic [N-1:0]        Result,
   output logic                busy,
   output logic                overrun
);

   state_t              r_state;
   logic [N-1:0]        r_bus_a;
   logic [N-1:0]        r_bus_b;
   logic [OPCODE_W-1:0] r_opcode;
   logic [N-1:0]        r_tx_data;
   logic                r_overrun;
   // Low for the first clock edge after reset release so strobes on that edge are ignored.
   logic                r_armed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= WAIT_A;
         r_bus_a   <= '0;
         r_bus_b   <= '0;
         r_opcode  <= '0;
         r_tx_data <= '0;
         r_overrun <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         if (r_armed) begin
            case (r_state)
               WAIT_A: begin
                  if (rx_done) begin
                     r_bus_a <= rx_data;
                     r_state <= WAIT_B;
                  end
               end
               WAIT_B: begin
                  if (rx_done) begin
                     r_bus_b <= rx_data;
                     r_state <= WAIT_OP;
                  end
               end
               WAIT_OP: begin
                  if (rx_done) begin
                     r_opcode <= rx_data[OPCODE_W-1:0];
                     r_state  <= EXEC;
                  end
               end
               EXEC: begin
                  if (rx_done) r_overrun <= 1'b1;
                  r_state <= SEND;
               end
               SEND: begin
                  if (rx_done) r_overrun <= 1'b1;
                  r_tx_data <= Result;
                  r_state   <= WAIT_TX;
               end
               WAIT_TX: begin
                  // A byte arriving with tx_done is still dropped, never taken as A.
                  if (rx_done) r_overrun <= 1'b1;
                  if (tx_done) r_state <= WAIT_A;
               end
               default: r_state <= WAIT_A;
            endcase
         end
      end
   end

   assign tx_start = (r_state == SEND);
   assign busy     = (r_state != WAIT_A);
   assign tx_data  = r_tx_data;
   assign BusA     = r_bus_a;
   assign BusB     = r_bus_b;
   assign OpCode   = r_opcode;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: directed and random operand/opcode triples through a
// behavioural ALU and a UART stub that answers tx_done five cycles after tx_start.
module tb_alu_uart_if;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_done;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [7:0] bus_a;
   logic [7:0] bus_b;
   logic [5:0] opcode;
   logic [7:0] result;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference state
   logic [7:0] m_a, m_b, m_tx;
   logic [5:0] m_op;
   logic       m_ovr;

   always #5 clk = ~clk;

   alu_uart_if #(.N(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_done  (rx_done),
      .rx_data  (rx_data),
      .tx_done  (tx_done),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .BusA     (bus_a),
      .BusB     (bus_b),
      .OpCode   (opcode),
      .Result   (result),
      .busy     (busy),
      .overrun  (overrun)
   );

   // MIPS-style function codes; shifts move operand A by one place.
   function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h00:   return a << 1;
         6'h02:   return a >> 1;
         6'h03:   return sa >>> 1;
         6'h2A:   return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   always_comb result = alu_fn(opcode, bus_a, bus_b);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with rx_done low again.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   // mode 0: clean; 1: extra byte early in WAIT_TX; 2: extra byte together with tx_done
   task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int mode, input bit use_exp, input logic [7:0] exp);
      send_byte(a);
      m_a = a;
      chk("load_a", {8'h0, bus_a}, {8'h0, m_a});
      chk("busy_b", {15'h0, busy}, 16'h1);
      send_byte(b);
      m_b = b;
      chk("load_b", {8'h0, bus_b}, {8'h0, m_b});
      send_byte(op);
      m_op = op[5:0];
      chk("load_op", {10'h0, opcode}, {10'h0, m_op});
      chk("txs_exec", {15'h0, tx_start}, 16'h0);
      @(negedge clk);
      chk("txs_latency", {15'h0, tx_start}, 16'h1);
      m_tx = alu_fn(m_op, m_a, m_b);
      @(negedge clk);
      chk("txs_once", {15'h0, tx_start}, 16'h0);
      chk("tx_data", {8'h0, tx_data}, {8'h0, m_tx});
      if (use_exp) chk("tx_const", {8'h0, tx_data}, {8'h0, exp});
      if (mode == 1) begin
         send_byte(8'h77);
         m_ovr = 1'b1;
         chk("ovr_set", {15'h0, overrun}, 16'h1);
         chk("ovr_bus_a", {8'h0, bus_a}, {8'h0, m_a});
         chk("ovr_busy", {15'h0, busy}, 16'h1);
         repeat (3) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      tx_done = 1'b1;
      if (mode == 2) begin
         rx_data = 8'h77;
         rx_done = 1'b1;
         m_ovr   = 1'b1;
      end
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
      chk("idle_busy", {15'h0, busy}, 16'h0);
      chk("idle_ovr", {15'h0, overrun}, {15'h0, m_ovr});
      chk("idle_bus_a", {8'h0, bus_a}, {8'h0, m_a});
      chk("hold_tx", {8'h0, tx_data}, {8'h0, m_tx});
   endtask

   task automatic check_cleared();
      chk("rst_bus_a", {8'h0, bus_a}, 16'h0);
      chk("rst_bus_b", {8'h0, bus_b}, 16'h0);
      chk("rst_opcode", {10'h0, opcode}, 16'h0);
      chk("rst_tx_data", {8'h0, tx_data}, 16'h0);
      chk("rst_tx_start", {15'h0, tx_start}, 16'h0);
      chk("rst_overrun", {15'h0, overrun}, 16'h0);
      chk("rst_busy", {15'h0, busy}, 16'h0);
   endtask

   // Async reset pulse started mid-cycle; released on a negedge, followed by the
   // ignored first edge carrying both strobes.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1 check_cleared();
      @(negedge clk);
      reset = 1'b0;
      m_a = 8'h0; m_b = 8'h0; m_op = 6'h0; m_tx = 8'h0; m_ovr = 1'b0;
      rx_data = 8'h5A;
      rx_done = 1'b1;
      tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      chk("release_bus_a", {8'h0, bus_a}, 16'h0);
      chk("release_busy", {15'h0, busy}, 16'h0);
   endtask

   initial begin
      logic [5:0] ops [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2A};
      logic [7:0] ra, rb, rop;
      int         rmode;

      reset   = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h0;
      tx_done = 1'b0;
      m_a = 8'h0; m_b = 8'h0; m_op = 6'h0; m_tx = 8'h0; m_ovr = 1'b0;
      repeat (2) @(negedge clk);
      check_cleared();
      reset = 1'b0;
      @(negedge clk);

      run_triple(8'h05, 8'h03, 8'h20, 0, 1'b1, 8'h08);
      run_triple(8'h03, 8'h05, 8'h22, 0, 1'b1, 8'hFE);
      run_triple(8'h80, 8'h00, 8'h03, 0, 1'b1, 8'hC0);
      run_triple(8'h80, 8'h00, 8'h02, 0, 1'b1, 8'h40);
      run_triple(8'h0C, 8'h0A, 8'hE5, 0, 1'b1, 8'h0E);
      chk("opcode_masked", {10'h0, opcode}, 16'h25);

      run_triple(8'h05, 8'h03, 8'h20, 1, 1'b1, 8'h08);
      run_triple(8'h07, 8'h02, 8'h22, 0, 1'b1, 8'h05);
      run_triple(8'h0C, 8'h0A, 8'h24, 2, 1'b1, 8'h08);
      chk("ovr_sticky", {15'h0, overrun}, 16'h1);

      send_byte(8'h11);
      send_byte(8'h22);
      pulse_reset();
      run_triple(8'h01, 8'h01, 8'h26, 0, 1'b1, 8'h00);

      for (int i = 0; i < 24; i++) begin
         ra    = 8'($urandom);
         rb    = 8'($urandom);
         rop   = {2'($urandom), ops[$urandom_range(0, 9)]};
         rmode = (i % 6 == 5) ? int'($urandom_range(1, 2)) : 0;
         run_triple(ra, rb, rop, rmode, 1'b0, 8'h00);
      end

      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h20);
      repeat (2) @(negedge clk);
      chk("pend_busy", {15'h0, busy}, 16'h1);
      pulse_reset();
      run_triple(8'h09, 8'h06, 8'h22, 0, 1'b1, 8'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
